usb_rx_dpdm: RTL and testbench
==============================

Name: usb_rx_dpdm

Overview:
- Parametrised receive-side DP/DM line decoder.
- Sits between the bus pins (bus_in) and the receive NRZI decoder; the protocol FSM controls it.
- Detects SYNC of configurable length and converts J/K symbols into a bit stream with a per-bit valid strobe.
- Counts a mode-selected packet length (token/data/handshake), checks EOP, and flags early-EOP, bad-EOP and, optionally, receive timeout.

Parameters:
- SYNC_LEN, 8, SYNC symbols: alternating K/J starting with K, last two symbols both K; legal 4..32, even.
- DATA_BITS, 88, payload bits after SYNC in data mode.
- TOKEN_BITS, 24, payload bits after SYNC in token mode.
- HSHAKE_BITS, 8, payload bits after SYNC in handshake mode.
- TIMEOUT_CYC, 1023, armed-idle cycles before rx_timeout (used only with macro).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bus_in  in  2  line state {DP,DM}: J=2'b10, K=2'b01, SE0=2'b00
- enable  in  1  local transmitter driving the bus; bus_in is ignored while high
- rx_mode  in  2  0=idle/disarmed, 1=token, 2=data, 3=handshake; held by protocol FSM while waiting
- abort  in  1  synchronous return to IDLE, highest priority
- err_ack  in  1  protocol FSM acknowledges error
- s_out  out  1  received bit: K->0, J->1
- s_valid  out  1  s_out valid this cycle
- start_nrzi  out  1  one-cycle pulse on the final SYNC symbol
- end_nrzi  out  1  one-cycle pulse on the cycle after the last payload bit
- got_sync  out  1  one-cycle pulse, same cycle as start_nrzi
- eop_error  out  1  EOP/framing error
- rx_timeout  out  1  one-cycle pulse

Behaviour:
- Symbol qualifiers: symJ/symK/symX = ~enable && bus_in matches the symbol. With enable high, no symbol is valid.
- Reset: state IDLE, all counters 0, all outputs 0.
- Output timing: s_out, s_valid, start_nrzi, got_sync, end_nrzi and eop_error are Mealy decodes of state plus the current sample (zero latency). rx_timeout is registered.
- State priority: abort beats every other input and forces IDLE next cycle, including from ERROR.
- IDLE:
  - symK && rx_mode!=0 -> SYNC; sync_cnt=1; total_bits loaded from rx_mode.
  - rx_mode is sampled only at this point; later changes are ignored until the next IDLE.
  - rx_mode==0 -> stay in IDLE.
- SYNC (sync_cnt=i symbols already matched):
  - Expected symbol for i<SYNC_LEN-1: K when i even, J when i odd. Expected symbol for i==SYNC_LEN-1: K.
  - Match with i<SYNC_LEN-1 -> sync_cnt+1.
  - Match with i==SYNC_LEN-1 -> DATA; bit_cnt=0; got_sync=start_nrzi=1.
  - Any mismatch, SE0 or enable high -> IDLE. No error is raised.
- DATA, bit_cnt<total_bits:
  - symK/symJ -> s_valid=1, s_out=0/1, bit_cnt+1.
  - symX -> early EOP: eop_error=1, go to ERROR.
  - enable high -> eop_error=1, go to ERROR.
- DATA, bit_cnt==total_bits: end_nrzi=1, bit_cnt cleared.
  - symX -> EOP2.
  - else eop_error=1, go to ERROR.
- EOP2: symX -> EOP3; else eop_error=1, go to ERROR.
- EOP3: symJ -> IDLE; else eop_error=1, go to ERROR.
- ERROR: eop_error held at 1. err_ack -> IDLE, else stay.
- Counter widths:
  - bit_cnt and total_bits are $clog2(max(DATA_BITS,TOKEN_BITS,HSHAKE_BITS)+1) bits wide.
  - sync_cnt is $clog2(SYNC_LEN) bits wide.
  - No wrap is possible, since each counter is cleared on leaving its state.

Optional Feature:
- Macro: USB_RX_TIMEOUT_EN.
- Defined:
  - A timeout counter increments each cycle in IDLE while rx_mode!=0.
  - It clears on leaving IDLE, on rx_mode==0, or on abort.
  - On reaching TIMEOUT_CYC-1, rx_timeout pulses for one cycle on the following cycle and the counter restarts from 0. State remains IDLE.
- Undefined: no timeout counter is built; rx_timeout is tied to 0.

Decomposition:
- Package usb_rx_pkg:
  - Symbol constants SYM_J/SYM_K/SYM_SE0.
  - rx_mode_t enum (RX_NONE, RX_TOKEN, RX_DATA, RX_HSHAKE).
  - rx_state_t enum (IDLE, SYNC, DATA, EOP2, EOP3, ERROR).
  - Default length constants.
- Sub-module usb_sync_det(SYNC_LEN): the sync_cnt pattern matcher. Outputs sync_match_last and sync_fail.
- Bit and timeout counters reuse the codebase counter module.

Test Plan:
- Handshake mode: KJKJKJKK, 8 bits J,K,K,J,J,J,K,J, then SE0,SE0,J -> got_sync on symbol 8; s_out=1,0,0,1,1,1,0,1 with s_valid for 8 cycles; end_nrzi on the 9th; eop_error never asserted; back to IDLE.
- Data mode (88 bits) and token mode (24 bits) back to back -> exactly 88 then 24 s_valid strobes; end_nrzi at the correct cycle each time.
- Bad SYNC KJKJJ... -> return to IDLE with no outputs asserted; a clean SYNC that follows is accepted.
- SE0 at data bit 5 of a handshake -> eop_error that cycle; held in ERROR until err_ack; then IDLE.
- Wrong EOP (SE0,J): eop_error in EOP2. Separately, abort during DATA -> IDLE next cycle with no eop_error.
- With USB_RX_TIMEOUT_EN and TIMEOUT_CYC=16: rx_mode=2 held on a J bus -> rx_timeout pulses every 16 cycles. Without the macro, rx_timeout stays 0.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared line-symbol encodings, receive mode and state enums,
// and default packet-length constants for the DP/DM receive decoder.
package usb_rx_pkg;

    // Line states as sampled {DP,DM}
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    typedef enum logic [1:0] {
        RX_NONE   = 2'd0,
        RX_TOKEN  = 2'd1,
        RX_DATA   = 2'd2,
        RX_HSHAKE = 2'd3
    } rx_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        EOP2  = 3'd3,
        EOP3  = 3'd4,
        ERROR = 3'd5
    } rx_state_t;

    localparam int DEF_SYNC_LEN    = 8;
    localparam int DEF_DATA_BITS   = 88;
    localparam int DEF_TOKEN_BITS  = 24;
    localparam int DEF_HSHAKE_BITS = 8;
    localparam int DEF_TIMEOUT_CYC = 1023;

    // Largest of three lengths; sizes the shared payload bit counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_rx_counter.sv
// usb_rx_counter: generic up-counter with synchronous clear (clear wins
// over increment) and asynchronous active-low reset.
module usb_rx_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, otherwise step when asked
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/usb_sync_det.sv
// usb_sync_det: SYNC pattern matcher. Tracks how many SYNC symbols have
// matched so far (the first K is matched by the caller on start_i) and
// reports a match of the final symbol or any mismatch.
// Pattern: K,J,K,J,...,K,K -- alternating from K, last two both K.
module usb_sync_det #(
    parameter int SYNC_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,            // first K seen, begin counting at 1
    input  logic active_i,           // in SYNC state and not aborted
    input  logic sym_k_i,
    input  logic sym_j_i,
    output logic sync_match_last_o,
    output logic sync_fail_o
);

    localparam int CW = $clog2(SYNC_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(SYNC_LEN - 1);

    logic [CW-1:0] sync_cnt_q;
    logic [CW-1:0] sync_cnt_d;
    logic          is_last;
    logic          expect_k;
    logic          match;

    assign is_last  = (sync_cnt_q == LAST_IDX);
    // Even positions and the final position expect K, odd positions J
    assign expect_k = is_last || !sync_cnt_q[0];
    assign match    = expect_k ? sym_k_i : sym_j_i;

    assign sync_match_last_o = active_i && match && is_last;
    assign sync_fail_o       = active_i && !match;

    // Advance on each matched symbol, clear whenever SYNC is left
    always_comb begin
        sync_cnt_d = '0;
        if (start_i) begin
            sync_cnt_d = CW'(1);
        end else if (active_i && match && !is_last) begin
            sync_cnt_d = sync_cnt_q + CW'(1);
        end
    end

    // Symbol position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt_q <= '0;
        end else begin
            sync_cnt_q <= sync_cnt_d;
        end
    end

endmodule

// File: rtl/usb_rx_dpdm.sv
// usb_rx_dpdm: receive-side DP/DM line decoder. Detects SYNC, converts
// J/K symbols to bits with a valid strobe for a mode-selected payload
// length, then checks the SE0,SE0,J end-of-packet.
// Optional build macro USB_RX_TIMEOUT_EN adds an armed-idle receive
// timeout; without it rx_timeout is constant 0.
module usb_rx_dpdm
    import usb_rx_pkg::*;
#(
    parameter int SYNC_LEN    = DEF_SYNC_LEN,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int TOKEN_BITS  = DEF_TOKEN_BITS,
    parameter int HSHAKE_BITS = DEF_HSHAKE_BITS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bus_in,
    input  logic       enable,
    input  logic [1:0] rx_mode,
    input  logic       abort,
    input  logic       err_ack,
    output logic       s_out,
    output logic       s_valid,
    output logic       start_nrzi,
    output logic       end_nrzi,
    output logic       got_sync,
    output logic       eop_error,
    output logic       rx_timeout
);

    localparam int MAX_BITS = max3(DATA_BITS, TOKEN_BITS, HSHAKE_BITS);
    localparam int BW       = $clog2(MAX_BITS + 1);

    // Reject illegal parameter sets at elaboration time
    if (SYNC_LEN < 4 || SYNC_LEN > 32 || (SYNC_LEN % 2) != 0 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("usb_rx_dpdm: illegal SYNC_LEN or TIMEOUT_CYC");
    end

    rx_state_t      state_q;
    rx_state_t      state_d;
    logic [BW-1:0]  total_bits_q;
    logic [BW-1:0]  total_bits_d;
    logic [BW-1:0]  bit_cnt;

    logic sym_j;
    logic sym_k;
    logic sym_x;
    logic sync_start;
    logic sync_last;
    logic sync_fail;
    logic bit_inc;

    logic s_out_c;
    logic s_valid_c;
    logic start_c;
    logic end_c;
    logic eop_c;

    // The bus is ignored while our own transmitter drives it
    assign sym_j = !enable && (bus_in == SYM_J);
    assign sym_k = !enable && (bus_in == SYM_K);
    assign sym_x = !enable && (bus_in == SYM_SE0);

    usb_sync_det #(
        .SYNC_LEN (SYNC_LEN)
    ) u_sync_det (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_i           (sync_start),
        .active_i          ((state_q == SYNC) && !abort),
        .sym_k_i           (sym_k),
        .sym_j_i           (sym_j),
        .sync_match_last_o (sync_last),
        .sync_fail_o       (sync_fail)
    );

    // Payload bit counter: steps on each received bit, cleared otherwise
    usb_rx_counter #(
        .W (BW)
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!bit_inc),
        .inc_i (bit_inc),
        .cnt_o (bit_cnt)
    );

    // Next-state and Mealy output decode from state plus current sample
    always_comb begin
        state_d      = state_q;
        total_bits_d = total_bits_q;
        sync_start   = 1'b0;
        bit_inc      = 1'b0;
        s_out_c      = 1'b0;
        s_valid_c    = 1'b0;
        start_c      = 1'b0;
        end_c        = 1'b0;
        eop_c        = 1'b0;
        if (abort) begin
            // Abort overrides everything; only the held error flag remains visible
            state_d = IDLE;
            eop_c   = (state_q == ERROR);
        end else begin
            case (state_q)
                IDLE: begin
                    if (sym_k && (rx_mode != RX_NONE)) begin
                        state_d    = SYNC;
                        sync_start = 1'b1;
                        case (rx_mode)
                            RX_TOKEN:  total_bits_d = BW'(TOKEN_BITS);
                            RX_DATA:   total_bits_d = BW'(DATA_BITS);
                            default:   total_bits_d = BW'(HSHAKE_BITS);
                        endcase
                    end
                end
                SYNC: begin
                    if (sync_last) begin
                        state_d = DATA;
                        start_c = 1'b1;
                    end else if (sync_fail) begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (bit_cnt != total_bits_q) begin
                        if (sym_k || sym_j) begin
                            s_valid_c = 1'b1;
                            s_out_c   = sym_j;
                            bit_inc   = 1'b1;
                        end else begin
                            eop_c   = 1'b1;
                            state_d = ERROR;
                        end
                    end else begin
                        end_c = 1'b1;
                        if (sym_x) begin
                            state_d = EOP2;
                        end else begin
                            eop_c   = 1'b1;
                            state_d = ERROR;
                        end
                    end
                end
                EOP2: begin
                    if (sym_x) begin
                        state_d = EOP3;
                    end else begin
                        eop_c   = 1'b1;
                        state_d = ERROR;
                    end
                end
                EOP3: begin
                    if (sym_j) begin
                        state_d = IDLE;
                    end else begin
                        eop_c   = 1'b1;
                        state_d = ERROR;
                    end
                end
                ERROR: begin
                    eop_c = 1'b1;
                    if (err_ack) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and latched payload length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            total_bits_q <= '0;
        end else begin
            state_q      <= state_d;
            total_bits_q <= total_bits_d;
        end
    end

    assign s_out      = s_out_c;
    assign s_valid    = s_valid_c;
    assign start_nrzi = start_c;
    assign got_sync   = start_c;
    assign end_nrzi   = end_c;
    assign eop_error  = eop_c;

`ifdef USB_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          to_inc;
    logic          to_hit;
    logic          rx_timeout_q;
    logic          rx_timeout_d;

    // Count only while armed and staying idle; restart after each expiry
    assign to_inc       = (state_q == IDLE) && (state_d == IDLE) && (rx_mode != RX_NONE) && !abort;
    assign to_hit       = to_inc && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign rx_timeout_d = to_hit;

    usb_rx_counter #(
        .W (TW)
    ) u_to_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!to_inc || to_hit),
        .inc_i (to_inc),
        .cnt_o (to_cnt)
    );

    // Registered one-cycle timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_timeout_q <= 1'b0;
        end else begin
            rx_timeout_q <= rx_timeout_d;
        end
    end

    assign rx_timeout = rx_timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_dpdm.sv
// tb_usb_rx_dpdm: scoreboard bench for usb_rx_dpdm. Stimulus tasks push the
// cycle number and expected output vector of every cycle on which some
// output should be asserted; a negedge monitor compares each such cycle and
// flags any output asserted on a cycle with no expectation.
// Expected vector: {rx_timeout, s_valid, s_out, start_nrzi, got_sync, end_nrzi, eop_error}
module tb_usb_rx_dpdm;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    localparam logic [6:0] E_TO   = 7'b1000000;
    localparam logic [6:0] E_J    = 7'b0110000;
    localparam logic [6:0] E_K    = 7'b0100000;
    localparam logic [6:0] E_SYNC = 7'b0001100;
    localparam logic [6:0] E_END  = 7'b0000010;
    localparam logic [6:0] E_ERR  = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bus_in = J;
    logic       enable = 1'b0;
    logic [1:0] rx_mode = 2'd0;
    logic       abort = 1'b0;
    logic       err_ack = 1'b0;
    logic       s_out, s_valid, start_nrzi, end_nrzi, got_sync, eop_error, rx_timeout;

    // Values applied by the next step() call
    logic [1:0] md_v = 2'd0;
    logic       en_v = 1'b0;
    logic       ab_v = 1'b0;
    logic       ack_v = 1'b0;

    typedef struct {
        int         cyc;
        logic [6:0] v;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    usb_rx_dpdm #(
        .SYNC_LEN    (8),
        .DATA_BITS   (88),
        .TOKEN_BITS  (24),
        .HSHAKE_BITS (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .enable     (enable),
        .rx_mode    (rx_mode),
        .abort      (abort),
        .err_ack    (err_ack),
        .s_out      (s_out),
        .s_valid    (s_valid),
        .start_nrzi (start_nrzi),
        .end_nrzi   (end_nrzi),
        .got_sync   (got_sync),
        .eop_error  (eop_error),
        .rx_timeout (rx_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare expected cycles, flag unexpected activity
    always @(negedge clk) begin
        logic [6:0] obs;
        obs = {rx_timeout, s_valid, s_out, start_nrzi, got_sync, end_nrzi, eop_error};
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                total++;
                if (obs !== exp_q[0].v) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, obs, exp_q[0].v);
                end else begin
                    $display("ok   outputs cyc=%0d val=%b", cyc, obs);
                end
                void'(exp_q.pop_front());
            end else if (obs !== 7'b0) begin
                total++;
                bad++;
                $display("FAIL unexpected cyc=%0d got=%b exp=0000000", cyc, obs);
            end
        end
    end

    // One bus symbol per cycle, with optional expected output vector
    task automatic step(input logic [1:0] b, input logic [6:0] e);
        @(posedge clk);
        #1;
        bus_in  = b;
        rx_mode = md_v;
        enable  = en_v;
        abort   = ab_v;
        err_ack = ack_v;
        if (e != 7'b0) exp_q.push_back('{cyc, e});
    endtask

    task automatic idle(input int n);
        md_v = 2'd0;
        for (int i = 0; i < n; i++) step(J, 7'b0);
    endtask

    task automatic sync_seq(input logic [1:0] mode);
        md_v = mode;
        for (int i = 0; i < 8; i++) begin
            if (i == 7)           step(K, E_SYNC);
            else if (i % 2 == 0)  step(K, 7'b0);
            else                  step(J, 7'b0);
        end
    endtask

    task automatic send_bits(input int n, input logic [127:0] v);
        for (int i = 0; i < n; i++) begin
            if (v[i]) step(J, E_J);
            else      step(K, E_K);
        end
    endtask

    task automatic eop_ok();
        step(SE0, E_END);
        step(SE0, 7'b0);
        step(J, 7'b0);
    endtask

    task automatic hold_error_then_ack();
        step(J, E_ERR);
        step(J, E_ERR);
        ack_v = 1'b1;
        step(J, E_ERR);
        ack_v = 1'b0;
        idle(2);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        total++;
        if ({rx_timeout, s_valid, s_out, start_nrzi, got_sync, end_nrzi, eop_error} !== 7'b0) begin
            bad++;
            $display("FAIL reset got=%b exp=0000000",
                     {rx_timeout, s_valid, s_out, start_nrzi, got_sync, end_nrzi, eop_error});
        end else begin
            $display("ok   reset outputs zero");
        end
        rst_n = 1'b1;
        idle(3);

        // Handshake packet: bits J,K,K,J,J,J,K,J
        sync_seq(2'd3);
        send_bits(8, 128'hB9);
        eop_ok();
        idle(2);

        // Data packet then token packet back to back
        sync_seq(2'd2);
        send_bits(88, {4{32'hA5C3_0F96}});
        eop_ok();
        sync_seq(2'd1);
        send_bits(24, 128'h3C96A1);
        eop_ok();
        idle(2);

        // Bad SYNC K,J,K,J,J -> silently back to IDLE, then a clean packet
        md_v = 2'd3;
        step(K, 7'b0);
        step(J, 7'b0);
        step(K, 7'b0);
        step(J, 7'b0);
        step(J, 7'b0);
        idle(2);
        sync_seq(2'd3);
        send_bits(8, 128'h5A);
        eop_ok();
        idle(2);

        // Early SE0 at data bit 5
        sync_seq(2'd3);
        send_bits(5, 128'h15);
        step(SE0, E_ERR);
        hold_error_then_ack();

        // Wrong EOP: SE0 then J
        sync_seq(2'd3);
        send_bits(8, 128'hC3);
        step(SE0, E_END);
        step(J, E_ERR);
        hold_error_then_ack();

        // Local transmitter enabled mid-payload
        sync_seq(2'd3);
        send_bits(2, 128'h2);
        en_v = 1'b1;
        step(J, E_ERR);
        en_v = 1'b0;
        hold_error_then_ack();

        // Abort during DATA, then a clean packet proves IDLE
        sync_seq(2'd3);
        send_bits(3, 128'h5);
        ab_v = 1'b1;
        step(SE0, 7'b0);
        ab_v = 1'b0;
        idle(2);
        sync_seq(2'd3);
        send_bits(8, 128'hB9);
        eop_ok();
        idle(2);

        // Armed idle on a J bus: timeout every 16 cycles when built in
        md_v = 2'd2;
        for (int k = 0; k < 40; k++) begin
`ifdef USB_RX_TIMEOUT_EN
            step(J, (k == 16 || k == 32) ? E_TO : 7'b0);
`else
            step(J, 7'b0);
`endif
        end
        idle(4);

        // Every expected event must have been seen
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d pending exp=0 pending", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
